// File: rtl/pe_conv1d_mac.sv
// pe_conv1d_mac: 1-D convolution processing element for the KWS PE grid.
// Holds K weight taps and a K-deep ifmap window. For each sample that fills
// the window, one signed 2-stage multiplier is shared over all K taps. The
// products are added to the incoming partial sum, and the result leaves over
// a valid/ready handshake.
// Build option: define PE_SAT_EN for saturating accumulation with a sticky
// ovf flag. Without it, accumulation wraps and ovf stays 0.
module pe_conv1d_mac #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int K      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              w_valid,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_loaded,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_ifmap,
    input  logic [ACC_W-1:0]  in_psum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_psum,
    output logic              ovf,
    output logic              busy
);
    localparam int PTR_W  = (K > 1) ? $clog2(K) : 1;
    localparam int FILL_W = $clog2(K + 1);
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                   state_r, state_s;
    logic signed [DATA_W-1:0] weight_r [K];
    logic signed [DATA_W-1:0] window_r [K];
    logic [PTR_W-1:0]         w_ptr_r;
    logic                     w_loaded_r;
    logic [FILL_W-1:0]        fill_r;
    logic [PTR_W-1:0]         idx_r;
    logic                     drain_cnt_r;
    logic signed [DATA_W-1:0] op_a_r, op_b_r;
    logic                     op_vld_r;
    logic signed [PROD_W-1:0] prod_r;
    logic                     prod_vld_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic                     ovf_r;
    logic                     out_valid_r;
    logic [ACC_W-1:0]         out_psum_r;
    logic                     in_ready_s, accept_s, window_full_s, last_issue_s;
    logic signed [ACC_W-1:0]  prod_ext_s;
    logic [ACC_W:0]           acc_sum_s;

    // Accumulator adder. It returns {overflow, result} and clamps only in saturating builds.
    function automatic logic [ACC_W:0] acc_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [ACC_W-1:0] b);
`ifdef PE_SAT_EN
        logic [ACC_W:0]   wide;
        logic [ACC_W-1:0] res;
        logic             over;
        wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        over = (wide[ACC_W] != wide[ACC_W-1]);
        if (over) begin
            if (wide[ACC_W]) begin
                res = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                res = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            res = wide[ACC_W-1:0];
        end
        return {over, res};
`else
        return {1'b0, a + b};
`endif
    endfunction

    assign in_ready_s    = (state_r == IDLE) && w_loaded_r && !out_valid_r && !clear;
    assign accept_s      = in_valid && in_ready_s;
    assign window_full_s = (fill_r >= FILL_W'(K - 1));
    assign last_issue_s  = (idx_r == PTR_W'(K - 1));
    assign prod_ext_s    = ACC_W'(prod_r);
    assign acc_sum_s     = acc_add(acc_r, prod_ext_s);

    // Next-state logic. clear overrides everything and returns the FSM to IDLE.
    always_comb begin
        state_s = state_r;
        if (clear) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_s = (accept_s && window_full_s) ? MAC : IDLE;
                MAC:     state_s = last_issue_s ? DRAIN : MAC;
                DRAIN:   state_s = drain_cnt_r ? OUT : DRAIN;
                OUT:     state_s = (out_valid_r && out_ready) ? IDLE : OUT;
                default: state_s = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Weight scratchpad load is accepted only while idle. The pointer wraps after tap K-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < K; i++) weight_r[i] <= '0;
            w_ptr_r    <= '0;
            w_loaded_r <= 1'b0;
        end else if ((state_r == IDLE) && w_valid) begin
            weight_r[w_ptr_r] <= w_data;
            if (w_ptr_r == PTR_W'(K - 1)) begin
                w_ptr_r    <= '0;
                w_loaded_r <= 1'b1;
            end else begin
                w_ptr_r <= w_ptr_r + PTR_W'(1);
            end
        end
    end

    // Sliding ifmap window. The newest sample is at index 0, and the fill count saturates at K.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            for (int i = 0; i < K; i++) window_r[i] <= '0;
            fill_r <= '0;
        end else if (accept_s) begin
            window_r[0] <= in_ifmap;
            for (int i = 1; i < K; i++) window_r[i] <= window_r[i-1];
            if (fill_r != FILL_W'(K)) fill_r <= fill_r + FILL_W'(1);
        end
    end

    // Tap issue counter plus the two multiplier stages (operand latch, product).
    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            idx_r       <= '0;
            drain_cnt_r <= 1'b0;
            op_a_r      <= '0;
            op_b_r      <= '0;
            op_vld_r    <= 1'b0;
            prod_r      <= '0;
            prod_vld_r  <= 1'b0;
        end else begin
            if (state_r == MAC) begin
                op_a_r   <= weight_r[idx_r];
                op_b_r   <= window_r[idx_r];
                op_vld_r <= 1'b1;
                idx_r    <= last_issue_s ? '0 : idx_r + PTR_W'(1);
            end else begin
                op_vld_r <= 1'b0;
                idx_r    <= '0;
            end
            prod_r      <= PROD_W'(op_a_r) * PROD_W'(op_b_r);
            prod_vld_r  <= op_vld_r;
            drain_cnt_r <= (state_r == DRAIN) ? ~drain_cnt_r : 1'b0;
        end
    end

    // Accumulator. It is preloaded with in_psum on the accepting edge, then adds each product as it leaves the multiplier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            acc_r <= '0;
            ovf_r <= 1'b0;
        end else if (accept_s && window_full_s) begin
            acc_r <= in_psum;
        end else if (prod_vld_r) begin
            acc_r <= acc_sum_s[ACC_W-1:0];
            ovf_r <= ovf_r | acc_sum_s[ACC_W];
        end
    end

    // Output register. It captures the finished sum once in OUT and holds it until the handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            out_valid_r <= 1'b0;
            out_psum_r  <= '0;
        end else if ((state_r == OUT) && !out_valid_r) begin
            out_valid_r <= 1'b1;
            out_psum_r  <= acc_r;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign w_loaded  = w_loaded_r;
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_psum  = out_psum_r;
    assign ovf       = ovf_r;
    assign busy      = (state_r != IDLE);
endmodule

// File: tb/tb_pe_conv1d_mac.sv
// Scoreboard bench for pe_conv1d_mac (K=3, plus a K=2/ACC_W=32 instance for the saturation boundary).
`timescale 1ns/1ps
module tb_pe_conv1d_mac;
    localparam int DW = 16;
    localparam int AW = 40;
    localparam int KT = 3;
    localparam longint MAXV = (longint'(1) <<< (AW - 1)) - longint'(1);
    localparam longint MINV = -(longint'(1) <<< (AW - 1));

    logic clk = 1'b0;
    logic reset;
    logic clear, w_valid, w_loaded, in_valid, in_ready, out_valid, out_ready, ovf, busy;
    logic [DW-1:0] w_data, in_ifmap;
    logic [AW-1:0] in_psum, out_psum;
    logic clear2, w_valid2, w_loaded2, in_valid2, in_ready2, out_valid2, out_ready2, ovf2, busy2;
    logic [DW-1:0] w_data2, in_ifmap2;
    logic [31:0] in_psum2, out_psum2;

    always #5 clk = ~clk;

    pe_conv1d_mac #(.DATA_W(DW), .ACC_W(AW), .K(KT)) dut (
        .clk(clk), .reset(reset), .clear(clear), .w_valid(w_valid), .w_data(w_data),
        .w_loaded(w_loaded), .in_valid(in_valid), .in_ready(in_ready), .in_ifmap(in_ifmap),
        .in_psum(in_psum), .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum),
        .ovf(ovf), .busy(busy));

    pe_conv1d_mac #(.DATA_W(DW), .ACC_W(32), .K(2)) dut2 (
        .clk(clk), .reset(reset), .clear(clear2), .w_valid(w_valid2), .w_data(w_data2),
        .w_loaded(w_loaded2), .in_valid(in_valid2), .in_ready(in_ready2), .in_ifmap(in_ifmap2),
        .in_psum(in_psum2), .out_valid(out_valid2), .out_ready(out_ready2), .out_psum(out_psum2),
        .ovf(ovf2), .busy(busy2));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ready_mode = 0;

    typedef struct {
        longint psum;
        bit     ovf;
        int     cyc;
    } exp_t;

    exp_t   sbq[$];
    exp_t   mon_e;
    longint last_exp = 0;
    logic   prev_v = 1'b0;
    longint w_m[KT];
    longint hist[$];
    int     fill_m = 0;
    bit     ovf_m = 1'b0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Reference model: convolution of the last KT samples with the taps, accumulated in tap order.
    function automatic void model_accept(longint x, longint ps, bit use_want, longint want, int acc_cyc);
        exp_t e;
        longint acc;
        hist.push_front(x);
        if (hist.size() > KT) void'(hist.pop_back());
        if (fill_m < KT) fill_m++;
        if (fill_m == KT) begin
            acc = ps;
            for (int k = 0; k < KT; k++) begin
                acc = acc + w_m[k] * hist[k];
`ifdef PE_SAT_EN
                if (acc > MAXV) begin acc = MAXV; ovf_m = 1'b1; end
                else if (acc < MINV) begin acc = MINV; ovf_m = 1'b1; end
`else
                acc = (acc <<< (64 - AW)) >>> (64 - AW);
`endif
            end
            e.psum = use_want ? want : acc;
            e.ovf  = ovf_m;
            e.cyc  = acc_cyc;
            sbq.push_back(e);
        end
    endfunction

    // Monitor: pops the scoreboard when out_valid rises and checks hold/stall behaviour while it stays high.
    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (sbq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_output: out_psum=%0d, expected no output", $signed(out_psum));
                end else begin
                    mon_e = sbq.pop_front();
                    last_exp = mon_e.psum;
                    chk("out_psum", $signed(out_psum), mon_e.psum);
                    chk("latency", cyc - mon_e.cyc, KT + 3);
                    chk("out_ovf", ovf, mon_e.ovf);
                end
            end else if (out_valid) begin
                chk("hold_psum", $signed(out_psum), last_exp);
                chk("in_ready_stall", in_ready, 0);
            end
            prev_v = out_valid;
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input longint x, input longint ps, input bit use_want = 1'b0, input longint want = 0);
        int n = 0;
        in_ifmap = DW'(x);
        in_psum  = AW'(ps);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin n++; @(negedge clk); end
        if (!in_ready) begin
            in_valid = 1'b0;
            checks++; failures++;
            $display("FAIL send_timeout: in_ready=0 after %0d cycles, expected 1", n);
        end else begin
            model_accept(x, ps, use_want, want, cyc + 1);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(sbq.size() == 0 && !busy && !out_valid) && n < 300) begin n++; @(negedge clk); end
        if (n >= 300) begin
            checks++; failures++;
            $display("FAIL idle_timeout: busy=%0d out_valid=%0d pending=%0d, expected idle", busy, out_valid, sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input longint w0, input longint w1, input longint w2, input bit chk_partial = 1'b0);
        longint wv[KT];
        wv = '{w0, w1, w2};
        for (int k = 0; k < KT; k++) begin
            if (chk_partial && k == KT - 1) chk("w_loaded_partial", w_loaded, 0);
            w_valid = 1'b1;
            w_data  = DW'(wv[k]);
            @(posedge clk);
            #1 w_m[k] = wv[k];
        end
        w_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        hist.delete();
        fill_m = 0;
        ovf_m  = 1'b0;
        sbq.delete();
        @(posedge clk);
        #1 clear = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [DW-1:0] rx;
        logic signed [AW-1:0] rp;
        longint rw[KT];
        int seen, n;
        longint p2, e2;
        bit eo2;
`ifndef PE_SAT_EN
        longint s2;
`endif
        reset = 1'b1; clear = 1'b0; w_valid = 1'b0; w_data = '0; in_valid = 1'b0;
        in_ifmap = '0; in_psum = '0; out_ready = 1'b1;
        clear2 = 1'b0; w_valid2 = 1'b0; w_data2 = '0; in_valid2 = 1'b0; in_ifmap2 = '0;
        in_psum2 = '0; out_ready2 = 1'b1;
        for (int k = 0; k < KT; k++) w_m[k] = 0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #1;

        // reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_psum", out_psum, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_w_loaded", w_loaded, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);

        // fill and output, w = {1,2,3}
        load_w(1, 2, 3, 1'b1);
        chk("w_loaded", w_loaded, 1);
        chk("in_ready_loaded", in_ready, 1);
        send(1, 0);
        idle_cycles(KT + 4);
        chk("fill1_no_out", out_valid, 0);
        chk("fill1_idle", busy, 0);
        send(2, 0);
        idle_cycles(KT + 4);
        chk("fill2_no_out", out_valid, 0);
        send(3, 0, 1'b1, 10);
        send(4, 0, 1'b1, 16);
        wait_idle();

        // psum chaining after a refill
        do_clear();
        send(2, 0);
        send(3, 0);
        send(4, -20, 1'b1, -4);
        wait_idle();

        // backpressure: out_ready held low for 10 cycles
        ready_mode = 2;
        send(5, 0, 1'b1, 22);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 30) begin n++; @(negedge clk); end
        chk("bp_out_valid", out_valid, 1);
        repeat (10) begin
            @(negedge clk);
            chk("bp_still_valid", out_valid, 1);
        end
        ready_mode = 0;
        n = 0;
        @(negedge clk);
        while (out_valid && n < 5) begin n++; @(negedge clk); end
        chk("bp_released", out_valid, 0);
        chk("bp_in_ready_back", in_ready, 1);
        @(posedge clk); #1;

        // clear two cycles into the MAC
        send(6, 0);
        @(posedge clk); #1;
        do_clear();
        seen = 0;
        repeat (KT + 6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("clear_no_output", seen, 0);
        chk("clear_idle", busy, 0);
        @(posedge clk); #1;
        send(7, 0);
        send(8, 0);
        idle_cycles(KT + 4);
        chk("clear_refill_no_out", out_valid, 0);
        send(9, 0, 1'b1, 46);
        wait_idle();

        // signed weights and samples
        do_clear();
        load_w(-1, 2, -3);
        send(-5, 0);
        send(7, 0);
        send(-9, 100, 1'b1, 138);
        send(11, -1000, 1'b1, -1050);
        wait_idle();

        // randomized traffic with backpressure, reloads and occasional clears
        ready_mode = 1;
        for (int i = 0; i < 150; i++) begin
            if (i % 50 == 0) begin
                wait_idle();
                for (int k = 0; k < KT; k++) begin rx = DW'($urandom); rw[k] = rx; end
                load_w(rw[0], rw[1], rw[2]);
            end
            if ($urandom_range(0, 29) == 0) do_clear();
            rx = DW'($urandom);
            case ($urandom_range(0, 7))
                0:       rp = AW'(MAXV - longint'($urandom_range(0, 1000)));
                1:       rp = AW'(MINV + longint'($urandom_range(0, 1000)));
                default: rp = AW'({$urandom(), $urandom()});
            endcase
            send(rx, rp);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
        end
        ready_mode = 0;
        wait_idle();

        // async reset while out_valid is high
        ready_mode = 2;
        do_clear();
        send(1, 0);
        send(2, 0);
        send(3, 0);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 30) begin n++; @(negedge clk); end
        chk("rst_mid_valid_before", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_out_psum", out_psum, 0);
        chk("rst_mid_w_loaded", w_loaded, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_in_ready", in_ready, 0);
        sbq.delete(); hist.delete(); fill_m = 0; ovf_m = 1'b0;
        for (int k = 0; k < KT; k++) w_m[k] = 0;
        ready_mode = 0;
        @(posedge clk); #3 reset = 1'b0;
        idle_cycles(5);
        chk("rst_in_ready_unloaded", in_ready, 0);
        load_w(1, 1, 1);
        chk("rst_in_ready_reloaded", in_ready, 1);

        // saturation boundary on the K=2, ACC_W=32 instance
        for (int k = 0; k < 2; k++) begin
            w_valid2 = 1'b1; w_data2 = 16'sd32767;
            @(posedge clk); #1;
        end
        w_valid2 = 1'b0;
        for (int s = 0; s < 2; s++) begin
            in_ifmap2 = 16'sd32767;
            in_psum2  = (s == 1) ? 32'h6000_0000 : 32'h0000_0000;
            in_valid2 = 1'b1;
            n = 0;
            @(negedge clk);
            while (!in_ready2 && n < 30) begin n++; @(negedge clk); end
            chk("sat_in_ready", in_ready2, 1);
            @(posedge clk); #1 in_valid2 = 1'b0;
        end
        n = 0;
        @(negedge clk);
        while (!out_valid2 && n < 30) begin n++; @(negedge clk); end
        p2 = longint'(32767) * longint'(32767);
`ifdef PE_SAT_EN
        e2 = longint'(32'h7FFF_FFFF);
        eo2 = 1'b1;
`else
        s2 = longint'(32'h6000_0000) + longint'(2) * p2;
        e2 = (s2 <<< 32) >>> 32;
        eo2 = 1'b0;
`endif
        chk("sat_out_valid", out_valid2, 1);
        chk("sat_out_psum", $signed(out_psum2), e2);
        chk("sat_ovf", ovf2, eo2);
        @(posedge clk); #1;

        idle_cycles(3);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
